// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - sequential unsigned non-restoring divider with start/done handshake
// One add-or-subtract of the divisor per cycle, then a single remainder fix-up step.
module nonrestoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_step;
  logic [WIDTH:0]   p_fix;

  assign accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign d_ext   = {1'b0, d_q};
  assign p_shift = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
  // Sign of the partial remainder before the shift picks add vs subtract.
  assign p_step  = p_q[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
  assign p_fix   = p_q[WIDTH] ? (p_q + d_ext) : p_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    a_d     = a_q;
    p_d     = p_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            d_d     = divisor;
            a_d     = dividend;
            p_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        p_d   = p_step;
        a_d   = {a_q[WIDTH-2:0], ~p_step[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        p_d     = p_fix;
        quot_d  = a_q;
        rem_d   = p_fix[WIDTH-1:0];
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      a_q     <= '0;
      p_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      a_q     <= a_d;
      p_q     <= p_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb/tb_nonrestoring_divider.sv - scoreboard bench for nonrestoring_divider (WIDTH=4)
module tb_nonrestoring_divider;

  localparam int W   = 4;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // done becomes visible right after edge 'due'; that edge number equals cyc at the following negedge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", 32'(quotient), 32'(e.q));
          chk("remainder", 32'(remainder), 32'(e.r));
          chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
          chk("done_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("missing_done", 32'(done), 32'(1));
        void'(sb.pop_front());
      end
    end
  end

  // Called at a negedge; accept edge is cyc+1, latency is 0 for divide-by-zero.
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    e.q = q; e.r = r; e.z = z;
    e.due = cyc + 1 + (z ? 0 : LAT);
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                     input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    @(negedge clk);
    issue(dvd, dvs, q, r, z);
    repeat (LAT + 2) @(posedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_quotient", 32'(quotient), 32'(0));
    chk("rst_remainder", 32'(remainder), 32'(0));
    chk("rst_dbz", 32'(div_by_zero), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_done", 32'(done), 32'(0));
    end

    // 13/3 with busy profile: high after E0..E4, low with done after E5
    issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_calc", 32'(busy), 32'(1));
      chk("done_early", 32'(done), 32'(0));
      if (i < 4) @(posedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_fix", 32'(busy), 32'(0));
    chk("done_after_fix", 32'(done), 32'(1));
    repeat (2) @(posedge clk);

    // 15/1, checking the previous result is held during CALC
    @(negedge clk);
    issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("hold_quotient", 32'(quotient), 32'(4));
    chk("hold_remainder", 32'(remainder), 32'(1));
    repeat (LAT) @(posedge clk);

    run(4'd7,  4'd9,  4'd0, 4'd7, 1'b0);
    run(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    run(4'd0,  4'd5,  4'd0, 4'd0, 1'b0);

    // Divide by zero, then a normal division clears the flag
    @(negedge clk);
    issue(4'd5, 4'd0, 4'd15, 4'd5, 1'b1);
    @(negedge clk);
    chk("dbz_busy", 32'(busy), 32'(0));
    chk("dbz_done", 32'(done), 32'(1));
    @(negedge clk);
    chk("dbz_busy_after", 32'(busy), 32'(0));
    run(4'd6, 4'd2, 4'd3, 4'd0, 1'b0);

    // start held 14 cycles: accepts at a, a+6, a+12; operands switch to 9/4 while busy
    @(negedge clk);
    begin
      exp_t e;
      int a;
      a = cyc + 1;
      e.z = 1'b0;
      e.q = 4'd4; e.r = 4'd1; e.due = a + LAT;      sb.push_back(e);
      e.q = 4'd2; e.r = 4'd1; e.due = a + 6 + LAT;  sb.push_back(e);
      e.q = 4'd2; e.r = 4'd1; e.due = a + 12 + LAT; sb.push_back(e);
      dividend = 4'd13;
      divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1 dividend = 4'd9;
      divisor  = 4'd4;
      repeat (11) @(posedge clk);
      #1 start = 1'b0;
    end
    repeat (LAT + 3) @(posedge clk);

    // Reset during CALC aborts without done
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_quotient", 32'(quotient), 32'(0));
    chk("abort_remainder", 32'(remainder), 32'(0));
    chk("abort_dbz", 32'(div_by_zero), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'(0));
    run(4'd10, 4'd3, 4'd3, 4'd1, 1'b0);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
